// File: rtl/inertial_intf.sv
// inertial_intf: gyro power-up/config and yaw-rate read sequencer above SPI_mnrch; optional offset calibration via YAW_CAL_EN
module inertial_intf #(
  parameter int PWRUP_BITS = 16,
  parameter int CAL_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        cal_done
);
  typedef enum logic [2:0] {PWRUP, CFG1, CFG2, WAIT_INT, RD_L, RD_H, OUT} state_t;
  state_t state;
  logic int_meta, int_sync;
  logic [PWRUP_BITS-1:0] pwr_cnt;
  logic [7:0] yaw_l;
  logic [15:0] raw, yaw_adj;
  logic cal_busy;
  logic unused_hi;
  assign raw = {rd_data[7:0], yaw_l};
  assign unused_hi = ^rd_data[15:8];
  // two-flop synchronizer for the asynchronous data-ready line
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {int_meta, int_sync} <= 2'b00;
    else {int_meta, int_sync} <= {INT, int_meta};
`ifdef YAW_CAL_EN
  logic signed [15+CAL_SHIFT:0] accum, accum_nxt;
  logic [CAL_SHIFT-1:0] cal_cnt;
  logic [15:0] offset;
  assign accum_nxt = accum + {{CAL_SHIFT{raw[15]}}, raw};
  assign cal_busy = !cal_done;
  assign yaw_adj = raw - offset;
  // accumulate the first 2^CAL_SHIFT samples, then latch their average as the offset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      accum <= '0;
      cal_cnt <= '0;
      offset <= '0;
      cal_done <= 1'b0;
    end else if (state == RD_H && done && !cal_done) begin
      accum <= accum_nxt;
      cal_cnt <= cal_cnt + 1'b1;
      if (&cal_cnt) begin
        offset <= accum_nxt[15+CAL_SHIFT:CAL_SHIFT];
        cal_done <= 1'b1;
      end
    end
`else
  assign cal_busy = 1'b0;
  assign yaw_adj = raw;
  // without calibration the output is usable as soon as reset is released
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cal_done <= 1'b0;
    else cal_done <= 1'b1;
`endif
  // command sequencer: power-up delay, two config writes, then low/high yaw reads per INT
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= PWRUP;
      pwr_cnt <= '0;
      yaw_l <= '0;
      wrt <= 1'b0;
      cmd <= '0;
      yaw_rt <= '0;
      vld <= 1'b0;
    end else begin
      wrt <= 1'b0;
      vld <= 1'b0;
      case (state)
        PWRUP: begin
          pwr_cnt <= pwr_cnt + 1'b1;
          if (&pwr_cnt) begin
            wrt <= 1'b1;
            cmd <= 16'h0D02;
            state <= CFG1;
          end
        end
        CFG1: if (done) begin
          wrt <= 1'b1;
          cmd <= 16'h1160;
          state <= CFG2;
        end
        CFG2: if (done) state <= WAIT_INT;
        WAIT_INT: if (int_sync) begin
          wrt <= 1'b1;
          cmd <= 16'hA600;
          state <= RD_L;
        end
        RD_L: if (done) begin
          yaw_l <= rd_data[7:0];
          wrt <= 1'b1;
          cmd <= 16'hA700;
          state <= RD_H;
        end
        RD_H: if (done) begin
          if (!cal_busy) begin
            yaw_rt <= yaw_adj;
            vld <= 1'b1;
          end
          state <= OUT;
        end
        OUT: state <= WAIT_INT;
        default: state <= PWRUP;
      endcase
    end
endmodule

// File: tb/tb_inertial_intf.sv
// tb_inertial_intf: directed bench for inertial_intf with an inline SPI_mnrch responder
module tb_inertial_intf;
  logic clk = 1'b0, rst_n = 1'b0, int_line = 1'b0, done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic wrt, vld, cal_done;
  logic [15:0] cmd, yaw_rt;
  int checks = 0, errors = 0, wrt_cnt = 0, vld_cnt = 0, ovl = 0, v0;
  bit busy = 1'b0;
`ifdef YAW_CAL_EN
  localparam logic [15:0] OFF = 16'h0020;
  localparam logic CAL = 1'b1;
`else
  localparam logic [15:0] OFF = 16'h0000;
  localparam logic CAL = 1'b0;
`endif

  inertial_intf #(.PWRUP_BITS(4), .CAL_SHIFT(1)) dut (
    .clk(clk), .rst_n(rst_n), .INT(int_line), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .yaw_rt(yaw_rt), .vld(vld), .cal_done(cal_done)
  );

  always #5 clk = ~clk;

  // transaction monitor: counts pulses and flags a wrt issued while one is outstanding
  always @(posedge clk) begin
    if (!rst_n) busy <= 1'b0;
    else if (wrt) begin
      if (busy) ovl <= ovl + 1;
      busy <= 1'b1;
    end else if (done) busy <= 1'b0;
    wrt_cnt <= wrt_cnt + int'(wrt);
    vld_cnt <= vld_cnt + int'(vld);
  end

  task automatic chk(input logic [15:0] obs, input logic [15:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input logic obs, input logic exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic wait_wrt(input logic [15:0] c, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!wrt && n < 200);
    chkb(wrt, 1'b1, {tag, "_wrt"});
    chk(cmd, c, {tag, "_cmd"});
  endtask

  task automatic xfer(input logic [15:0] d);
    repeat (2) @(negedge clk);
    rd_data = d;
    done = 1'b1;
    @(posedge clk);
    #1 done = 1'b0;
    rd_data = 16'hDEAD;
  endtask

  task automatic powerup();
    int n = 0;
    int w0;
    do begin @(negedge clk); n++; end while (!wrt && n < 100);
    chk(16'(n), 16'd16, "pwrup_len");
    chk(cmd, 16'h0D02, "cfg1_cmd");
    @(negedge clk);
    chkb(wrt, 1'b0, "cfg1_wrt_pulse");
    xfer(16'h0000);
    wait_wrt(16'h1160, "cfg2");
    @(negedge clk);
    chkb(wrt, 1'b0, "cfg2_wrt_pulse");
    xfer(16'h0000);
    w0 = wrt_cnt;
    repeat (10) @(negedge clk);
    rd_data = 16'h1234;
    done = 1'b1;
    @(posedge clk);
    #1 done = 1'b0;
    repeat (10) @(negedge clk);
    chk(16'(wrt_cnt - w0), 16'd0, "idle_no_wrt");
    chkb(cal_done, !CAL, "cal_done_cfg");
  endtask

  task automatic sample(input logic [15:0] raw, input logic exp_vld, input logic [15:0] exp, input logic hold);
    int_line = 1'b1;
    wait_wrt(16'hA600, "rd_l");
    if (!hold) int_line = 1'b0;
    xfer({8'hC3, raw[7:0]});
    wait_wrt(16'hA700, "rd_h");
    xfer({8'h3C, raw[15:8]});
    @(negedge clk);
    chkb(vld, exp_vld, "vld_hi");
    if (exp_vld) chk(yaw_rt, exp, "yaw_rt");
    @(negedge clk);
    chkb(vld, 1'b0, "vld_lo");
    if (exp_vld) chk(yaw_rt, exp, "yaw_hold");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chkb(wrt, 1'b0, "rst_wrt");
    chk(cmd, 16'h0000, "rst_cmd");
    chk(yaw_rt, 16'h0000, "rst_yaw");
    chkb(vld, 1'b0, "rst_vld");
    chkb(cal_done, 1'b0, "rst_cal_done");
    @(negedge clk);
    rst_n = 1'b1;
    powerup();
`ifdef YAW_CAL_EN
    sample(16'h0010, 1'b0, 16'h0000, 1'b0);
    sample(16'h0030, 1'b0, 16'h0000, 1'b0);
    chkb(cal_done, 1'b1, "cal_done_set");
    sample(16'h0025, 1'b1, 16'h0005, 1'b0);
`endif
    v0 = vld_cnt;
    sample(16'h128D, 1'b1, 16'h128D - OFF, 1'b0);
    repeat (8) @(negedge clk);
    chk(yaw_rt, 16'h128D - OFF, "yaw_stable");
    sample(16'hCD3D, 1'b1, 16'hCD3D - OFF, 1'b1);
    sample(16'hD2AA, 1'b1, 16'hD2AA - OFF, 1'b0);
    chk(16'(vld_cnt - v0), 16'd3, "vld_count");
    int_line = 1'b1;
    wait_wrt(16'hA600, "rd_l_r");
    int_line = 1'b0;
    xfer(16'h0011);
    wait_wrt(16'hA700, "rd_h_r");
    #2 rst_n = 1'b0;
    #1;
    chkb(wrt, 1'b0, "mid_rst_wrt");
    chk(cmd, 16'h0000, "mid_rst_cmd");
    chk(yaw_rt, 16'h0000, "mid_rst_yaw");
    chkb(vld, 1'b0, "mid_rst_vld");
    chkb(cal_done, 1'b0, "mid_rst_cal_done");
    @(negedge clk);
    rst_n = 1'b1;
    powerup();
`ifdef YAW_CAL_EN
    sample(16'h0010, 1'b0, 16'h0000, 1'b0);
    sample(16'h0030, 1'b0, 16'h0000, 1'b0);
    chkb(cal_done, 1'b1, "cal_done_set_r");
`endif
    sample(16'h8001, 1'b1, 16'h8001 - OFF, 1'b0);
    chk(16'(ovl), 16'd0, "wrt_overlap");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
